// File: rtl/program_sequencer_if.sv
// Bus between the nibble-CPU program sequencer, its instruction ROM and the execute datapath.
// The step signal exists only when SEQ_SINGLE_STEP_EN is defined.
interface program_sequencer_if #(
    parameter int ADDR_W = 5
);
    logic              run;
`ifdef SEQ_SINGLE_STEP_EN
    logic              step;
`endif
    logic [ADDR_W-1:0] imem_address;
    logic [7:0]        imem_data;
    logic [7:0]        instr_reg;
    logic [7:0]        operand_reg;
    logic              exec_valid;
    logic              exec_done;
    logic              jump_en;
    logic [ADDR_W-1:0] jump_target;
    logic              halt;
    logic              halted;
    logic [ADDR_W-1:0] pc;

    modport master (
`ifdef SEQ_SINGLE_STEP_EN
        input  step,
`endif
        input  run, imem_data, exec_done, jump_en, jump_target, halt,
        output imem_address, instr_reg, operand_reg, exec_valid, halted, pc
    );

    modport slave (
`ifdef SEQ_SINGLE_STEP_EN
        output step,
`endif
        output run, imem_data, exec_done, jump_en, jump_target, halt,
        input  imem_address, instr_reg, operand_reg, exec_valid, halted, pc
    );
endinterface

// File: rtl/program_sequencer.sv
// Program sequencer for the nibble CPU: owns the PC, fetches 1/2-byte instructions, hands them to execute.
// Optional single-step pause between instructions is enabled by defining SEQ_SINGLE_STEP_EN.
module program_sequencer #(
    parameter int ADDR_W     = 5,
    parameter int LAST_ADDR  = 16,
    parameter int START_ADDR = 0
) (
    input  logic                 clk,
    input  logic                 reset,
    program_sequencer_if.master  bus
);
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FETCH1 = 3'd1,
        FETCH2 = 3'd2,
        EXEC   = 3'd3,
        HALTED = 3'd4
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_A  = ADDR_W'(LAST_ADDR);
    localparam logic [ADDR_W-1:0] START_A = ADDR_W'(START_ADDR);
    localparam logic [ADDR_W-1:0] ZERO_A  = {ADDR_W{1'b0}};
    localparam logic [ADDR_W-1:0] ONE_A   = {{(ADDR_W-1){1'b0}}, 1'b1};

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [7:0]        instr_q, instr_d;
    logic [7:0]        operand_q, operand_d;
    logic              exec_valid_q, exec_valid_d;
    logic              halted_q, halted_d;
    logic              resume_s;
    logic              pause_s;

    function automatic logic [ADDR_W-1:0] next_pc(input logic [ADDR_W-1:0] p);
        next_pc = (p == LAST_A) ? ZERO_A : (p + ONE_A);
    endfunction

`ifdef SEQ_SINGLE_STEP_EN
    assign resume_s = bus.run | bus.step;
    assign pause_s  = 1'b1;
`else
    assign resume_s = bus.run;
    assign pause_s  = 1'b0;
`endif

    // Next-state, PC and holding-register logic.
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        instr_d   = instr_q;
        operand_d = operand_q;
        case (state_q)
            IDLE: begin
                if (resume_s) begin
                    state_d = FETCH1;
                end else begin
                    state_d = IDLE;
                end
            end
            FETCH1: begin
                instr_d = bus.imem_data;
                pc_d    = next_pc(pc_q);
                // Opcode class 00 carries a second byte.
                if (bus.imem_data[7:6] == 2'b00) begin
                    state_d = FETCH2;
                end else begin
                    operand_d = 8'h00;
                    state_d   = EXEC;
                end
            end
            FETCH2: begin
                operand_d = bus.imem_data;
                pc_d      = next_pc(pc_q);
                state_d   = EXEC;
            end
            EXEC: begin
                if (bus.exec_done) begin
                    if (bus.jump_en) begin
                        pc_d = (bus.jump_target > LAST_A) ? ZERO_A : bus.jump_target;
                    end else begin
                        pc_d = pc_q;
                    end
                    if (bus.halt) begin
                        state_d = HALTED;
                    end else if (pause_s) begin
                        state_d = IDLE;
                    end else begin
                        state_d = FETCH1;
                    end
                end else begin
                    state_d = EXEC;
                end
            end
            HALTED: begin
                state_d = HALTED;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        exec_valid_d = (state_d == EXEC);
        halted_d     = (state_d == HALTED);
    end

    // State and output registers with asynchronous reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            pc_q         <= START_A;
            instr_q      <= 8'h00;
            operand_q    <= 8'h00;
            exec_valid_q <= 1'b0;
            halted_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            instr_q      <= instr_d;
            operand_q    <= operand_d;
            exec_valid_q <= exec_valid_d;
            halted_q     <= halted_d;
        end
    end

    assign bus.imem_address = pc_q;
    assign bus.pc           = pc_q;
    assign bus.instr_reg    = instr_q;
    assign bus.operand_reg  = operand_q;
    assign bus.exec_valid   = exec_valid_q;
    assign bus.halted       = halted_q;
endmodule

// File: tb/tb_program_sequencer.sv
// Randomized scoreboard bench for program_sequencer: a program interpreter predicts every executed instruction.
module tb_program_sequencer;
    localparam int ADDR_W = 5;
    localparam int LAST   = 16;
    localparam int NINSTR = 60;
`ifdef SEQ_SINGLE_STEP_EN
    localparam int STEP_EXTRA = 1;
`else
    localparam int STEP_EXTRA = 0;
`endif

    typedef struct {
        logic [7:0] instr;
        logic [7:0] op;
        int         pc;
        int         nbytes;
        int         dly;
    } exp_t;

    typedef struct {
        int   dly;
        logic jump;
        int   tgt;
        logic halt;
    } resp_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    program_sequencer_if #(.ADDR_W(ADDR_W)) bus ();

    program_sequencer #(.ADDR_W(ADDR_W), .LAST_ADDR(LAST), .START_ADDR(0)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    logic [7:0] rom [0:31];
    assign bus.imem_data = rom[bus.imem_address];

    exp_t  exp_q  [$];
    resp_t resp_q [$];
    int    n_pass  = 0;
    int    n_total = 0;
    int    final_pc = 0;

    task automatic chk(input string nm, input int act, input int expv);
        n_total++;
        if (act == expv) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", nm, act, expv, $time);
    endtask

    function automatic int nxt(input int p);
        return (p == LAST) ? 0 : p + 1;
    endfunction

    // Monitor: pops the expected instruction whenever a new EXEC period begins.
    initial begin
        bit   first = 1'b1;
        bit   prev_v = 1'b0;
        int   gap = 0;
        int   vlen = 0;
        int   exp_len = 0;
        exp_t e;
        forever begin
            @(negedge clk);
            if (!reset) begin
                if (bus.exec_valid && !prev_v) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_exec", 1, 0);
                        exp_len = 1;
                    end else begin
                        e = exp_q.pop_front();
                        chk("instr_reg", int'(bus.instr_reg), int'(e.instr));
                        chk("operand_reg", int'(bus.operand_reg), int'(e.op));
                        chk("pc_in_exec", int'(bus.pc), e.pc);
                        chk("imem_address", int'(bus.imem_address), e.pc);
                        if (!first) chk("fetch_cycles", gap, e.nbytes + STEP_EXTRA);
                        first   = 1'b0;
                        exp_len = e.dly + 1;
                    end
                    vlen = 0;
                end
                if (!bus.exec_valid && prev_v) chk("exec_valid_len", vlen, exp_len);
                if (bus.exec_valid) begin
                    vlen++;
                    gap = 0;
                end else begin
                    gap++;
                end
                prev_v = bus.exec_valid;
            end
        end
    end

    // Datapath model: finishes each instruction after its scripted delay; drives junk when not allowed to act.
    initial begin
        bit    busy = 1'b0;
        int    cnt = 0;
        resp_t r;
        bus.exec_done   = 1'b0;
        bus.jump_en     = 1'b0;
        bus.jump_target = '0;
        bus.halt        = 1'b0;
        forever begin
            @(negedge clk);
            if (bus.exec_valid) begin
                if (!busy) begin
                    if (resp_q.size() == 0) r = '{dly: 0, jump: 1'b0, tgt: 0, halt: 1'b1};
                    else r = resp_q.pop_front();
                    busy = 1'b1;
                    cnt  = 0;
                end
                if (cnt == r.dly) begin
                    bus.exec_done   = 1'b1;
                    bus.jump_en     = r.jump;
                    bus.jump_target = ADDR_W'(r.tgt);
                    bus.halt        = r.halt;
                    busy            = 1'b0;
                end else begin
                    bus.exec_done   = 1'b0;
                    bus.jump_en     = 1'($urandom_range(0, 1));
                    bus.jump_target = ADDR_W'($urandom_range(0, 31));
                    bus.halt        = 1'($urandom_range(0, 1));
                    cnt++;
                end
            end else begin
                bus.exec_done   = 1'($urandom_range(0, 1));
                bus.jump_en     = 1'($urandom_range(0, 1));
                bus.jump_target = ADDR_W'($urandom_range(0, 31));
                bus.halt        = 1'($urandom_range(0, 1));
            end
        end
    end

    // Stimulus: builds the program and its expected trace, then runs the directed phases.
    initial begin
        int    pc;
        exp_t  e;
        resp_t r;
        logic [7:0] b;

        for (int a = 0; a < 32; a++) rom[a] = 8'($urandom_range(0, 255));
        rom[0]  = 8'hA6;
        rom[1]  = 8'h39;
        rom[2]  = 8'h00;
        rom[16] = 8'hC3;

        pc = 0;
        for (int k = 0; k < NINSTR; k++) begin
            b       = rom[pc];
            e.instr = b;
            pc      = nxt(pc);
            if (b[7:6] == 2'b00) begin
                e.op     = rom[pc];
                pc       = nxt(pc);
                e.nbytes = 2;
            end else begin
                e.op     = 8'h00;
                e.nbytes = 1;
            end
            e.pc   = pc;
            r.dly  = (k == 0) ? 0 : $urandom_range(0, 4);
            r.jump = (k != 0) && ($urandom_range(0, 3) == 0);
            case ($urandom_range(0, 3))
                0:       r.tgt = LAST;
                1:       r.tgt = $urandom_range(LAST + 1, 31);
                default: r.tgt = $urandom_range(0, LAST);
            endcase
            r.halt = (k == NINSTR - 1);
            e.dly  = r.dly;
            if (r.jump) pc = (r.tgt > LAST) ? 0 : r.tgt;
            exp_q.push_back(e);
            resp_q.push_back(r);
        end
        final_pc = pc;

        reset    = 1'b1;
        bus.run  = 1'b0;
`ifdef SEQ_SINGLE_STEP_EN
        bus.step = 1'b0;
`endif
        @(negedge clk);
        chk("rst_pc", int'(bus.pc), 0);
        chk("rst_imem_address", int'(bus.imem_address), 0);
        chk("rst_instr_reg", int'(bus.instr_reg), 0);
        chk("rst_operand_reg", int'(bus.operand_reg), 0);
        chk("rst_exec_valid", int'(bus.exec_valid), 0);
        chk("rst_halted", int'(bus.halted), 0);
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("idle_exec_valid", int'(bus.exec_valid), 0);
            chk("idle_pc", int'(bus.pc), 0);
        end

        bus.run = 1'b1;
`ifdef SEQ_SINGLE_STEP_EN
        bus.step = 1'b1;
`endif
        for (int i = 0; i < 5000 && !bus.halted; i++) begin
            @(negedge clk);
`ifndef SEQ_SINGLE_STEP_EN
            if (i == 20) bus.run = 1'b0;
`endif
        end
        chk("halt_reached", int'(bus.halted), 1);
        chk("scoreboard_empty", exp_q.size(), 0);
        bus.run = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("halted_pc_frozen", int'(bus.pc), final_pc);
            chk("halted_flag", int'(bus.halted), 1);
            chk("halted_exec_valid", int'(bus.exec_valid), 0);
        end

        reset = 1'b1;
        #1;
        chk("async_rst_halted", int'(bus.halted), 0);
        rom[0] = 8'h39;
        @(negedge clk);
        reset   = 1'b0;
        bus.run = 1'b1;
`ifdef SEQ_SINGLE_STEP_EN
        bus.step = 1'b0;
`endif
        @(posedge clk);
        @(posedge clk);
        #2;
        chk("fetch2_pc", int'(bus.pc), 1);
        chk("fetch2_instr_reg", int'(bus.instr_reg), 8'h39);
        reset = 1'b1;
        #1;
        chk("midrst_pc", int'(bus.pc), 0);
        chk("midrst_instr_reg", int'(bus.instr_reg), 0);
        chk("midrst_operand_reg", int'(bus.operand_reg), 0);
        chk("midrst_exec_valid", int'(bus.exec_valid), 0);
        chk("midrst_halted", int'(bus.halted), 0);
        @(negedge clk);
        bus.run = 1'b0;
        reset   = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("post_rst_idle_valid", int'(bus.exec_valid), 0);
            chk("post_rst_idle_pc", int'(bus.pc), 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
